sisc_fetch_unit: RTL and testbench
==================================

Name: sisc_fetch_unit

Overview:
- PC, instruction register and instruction-memory front end of the SISC datapath; sits directly upstream of the control FSM.
- Consumes the FSM's PC/IR strobes (pc_rst, pc_write, pc_sel, br_sel, ir_load) and produces the decoded instruction fields (opcode, mm, register fields, imm) the FSM and datapath read.
- Fetches over a variable-latency req/ack memory port; reports stall through fetch_busy.

Parameters:
- AW, 16, PC / instruction-address width
- IW, 32, instruction width
- ACK_TIMEOUT, 255, max cycles imem_req may wait for imem_ack; 0 disables the timeout

Ports:
- clk  in  1  clock, all state on rising edge
- rst_f  in  1  reset, asynchronous, active-low
- pc_rst  in  1  sync PC clear / fetch abort (from FSM)
- pc_write  in  1  PC update strobe
- pc_sel  in  1  0 = sequential (PC+1), 1 = branch target
- br_sel  in  1  1 = absolute target (imm), 0 = relative target (PC+imm)
- ir_load  in  1  start instruction fetch at current PC
- imem_req  out  1  memory request, registered
- imem_addr  out  AW  fetch address, registered, stable while imem_req=1
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  IW  instruction word
- fetch_busy  out  1  high while a fetch is outstanding (state != IDLE)
- opcode  out  4  IR[31:28]
- mm  out  4  IR[27:24]
- rd  out  4  IR[23:20]
- rs  out  4  IR[19:16]
- rt  out  4  IR[15:12]
- imm  out  16  IR[15:0]
- pc_out  out  AW  current PC
- fetch_err  out  1  sticky: timeout or protocol violation

Behaviour:
- Reset (rst_f=0, async): PC=0, IR=0 (opcode NOOP), imem_req=0, imem_addr=0, inc_pend=0, wait counter=0, fetch_err=0, state=IDLE.
- FSM states are IDLE and WAIT.
- IDLE, ir_load=1:
  - imem_addr<=PC, imem_req<=1, state<=WAIT.
  - If pc_write=1 and pc_sel=0 in the same cycle, set inc_pend; the increment is deferred, not applied now.
- WAIT, imem_ack=0:
  - Hold imem_req and imem_addr; count++.
  - count==ACK_TIMEOUT (ACK_TIMEOUT≠0) → imem_req<=0, fetch_err<=1, IR and PC unchanged, inc_pend cleared, state<=IDLE.
- WAIT, imem_ack=1 (sampled at an edge with imem_req=1):
  - IR<=imem_rdata, imem_req<=0, count<=0, state<=IDLE.
  - If inc_pend: PC<=PC+1 in the same edge; inc_pend<=0.
- Minimum latency: ir_load at edge N; imem_req high in cycle N..N+1; ack in that cycle; IR and PC valid after edge N+1 (2 clocks).
- Branch (pc_write=1, pc_sel=1, state IDLE):
  - Target = imm when br_sel=1.
  - Target = PC+imm when br_sel=0, where PC is already incremented, imm is treated as two's complement, and the sum wraps mod 2^AW.
  - PC<=target on that edge.
- Sequential pc_write (pc_sel=0) in IDLE without ir_load: PC<=PC+1 immediately; 0xFFFF wraps to 0.
- Protocol violations (state WAIT):
  - ir_load=1, or pc_write=1 with pc_sel=1 → ignored, fetch_err<=1.
  - pc_write with pc_sel=0 in WAIT sets inc_pend (idempotent).
- imem_ack while imem_req=0 is ignored (no IR write, no error).
- pc_rst=1 (synchronous, highest priority over everything except rst_f):
  - PC<=0, imem_req<=0, inc_pend<=0, count<=0, state<=IDLE.
  - IR and fetch_err are kept.
  - An in-flight ack in the same cycle is discarded.
- Field outputs are continuous slices of IR; imm and rt overlap by design.
- pc_out = PC register.

Decomposition:
- Shared package sisc_pkg:
  - opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15)
  - am_imm=8
  - IR field bit positions
  - fetch state encoding
- One natural sub-module: sisc_pc_reg. It contains the PC register, the +1 incrementer and the absolute/relative target mux, with inputs for pc_rst, the apply-increment strobe and the apply-branch strobe. The top level holds the FSM, IR, timeout counter and error logic.

Test Plan:
- Reset then ir_load with ack in the first WAIT cycle and imem_rdata=0x81230000 → imem_addr=0, IR valid 2 clocks later; opcode=8, mm=1, rd=2, rs=3; pc_out=1 (inc_pend applied).
- ir_load with ack delayed 5 cycles → imem_req and imem_addr held 6 cycles, fetch_busy high throughout, PC increments only on the ack edge.
- PC=0x0010, IR imm=0xFFFE: pc_write=1, pc_sel=1, br_sel=0 → PC=0x000E. Same with br_sel=1, imm=0x0040 → PC=0x0040.
- ACK_TIMEOUT=4, no ack → imem_req drops after 4 wait cycles, fetch_err=1, PC and IR unchanged.
- pc_rst asserted in WAIT with imem_ack high in the same cycle → PC=0, state IDLE, IR unchanged, imem_req=0 next cycle.
- ir_load during WAIT → second request not issued, fetch_err=1. Async rst_f pulse mid-WAIT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/sisc_pkg.sv
// -----------------------------------------------------------------------------
// sisc_pkg
// Shared definitions for the SISC datapath: opcode and addressing-mode
// constants, instruction-register field positions, and the fetch-unit state
// encoding. Imported by the fetch unit and the PC register.
// -----------------------------------------------------------------------------
package sisc_pkg;

  // Opcodes (IR[31:28])
  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_LOD    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_SWP    = 4'd3;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_BNR    = 4'd7;
  localparam logic [3:0] OP_ALU_OP = 4'd8;
  localparam logic [3:0] OP_HLT    = 4'd15;

  // Addressing-mode value in the mm field selecting an immediate operand
  localparam logic [3:0] AM_IMM = 4'd8;

  // Instruction-register field positions (LSB of each field)
  localparam int IR_W       = 32;
  localparam int FLD_W      = 4;
  localparam int OPCODE_LSB = 28;
  localparam int MM_LSB     = 24;
  localparam int RD_LSB     = 20;
  localparam int RS_LSB     = 16;
  localparam int RT_LSB     = 12;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;

  // Fetch-unit state: WAIT means a request is outstanding on the memory port
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  // Extract one 4-bit register/opcode field from an instruction word
  function automatic logic [FLD_W-1:0] ir_field(input logic [IR_W-1:0] ir,
                                                input int             lsb);
    return ir[lsb +: FLD_W];
  endfunction

  // Extract the 16-bit immediate from an instruction word
  function automatic logic [IMM_W-1:0] ir_imm(input logic [IR_W-1:0] ir);
    return ir[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/sisc_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// sisc_pc_reg
// Program counter register with its +1 incrementer and the absolute/relative
// branch-target mux.
//
// Ports
//   clk       clock, rising edge
//   rst_f     asynchronous active-low reset, PC -> 0
//   pc_rst_i  synchronous clear, highest priority
//   br_i      load the branch target this edge
//   inc_i     increment PC this edge (ignored when br_i is set)
//   br_sel_i  1 = absolute target (imm), 0 = relative target (PC + imm)
//   imm_i     immediate from the instruction register, two's complement
//   pc_o      current PC
// -----------------------------------------------------------------------------
module sisc_pc_reg
  import sisc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_rst_i,
  input  logic             br_i,
  input  logic             inc_i,
  input  logic             br_sel_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic [AW-1:0]    pc_o
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] imm_sx;
  logic [AW-1:0] imm_zx;
  logic [AW-1:0] br_tgt;

  // The relative offset is sign-extended so negative imm values branch
  // backwards; the absolute target uses imm as an unsigned address.
  assign imm_sx = AW'($signed(imm_i));
  assign imm_zx = AW'(imm_i);
  assign br_tgt = br_sel_i ? imm_zx : (pc_q + imm_sx);

  always_comb begin
    pc_d = pc_q;
    if (pc_rst_i) begin
      pc_d = '0;
    end else if (br_i) begin
      pc_d = br_tgt;
    end else if (inc_i) begin
      pc_d = pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/sisc_fetch_unit.sv
// -----------------------------------------------------------------------------
// sisc_fetch_unit
// PC, instruction register and instruction-memory front end of the SISC
// datapath. Takes the control FSM's PC/IR strobes, fetches instruction words
// over a variable-latency req/ack port and presents the decoded IR fields.
//
// Ports
//   clk, rst_f         clock (rising edge) / async active-low reset
//   pc_rst             sync PC clear and fetch abort
//   pc_write           PC update strobe; pc_sel picks sequential or branch
//   pc_sel, br_sel     0/1 = PC+1 / branch; branch absolute(1) / relative(0)
//   ir_load            start a fetch at the current PC
//   imem_req/addr      registered request and address, held until ack
//   imem_ack/rdata     read-data strobe and instruction word
//   fetch_busy         a fetch is outstanding
//   opcode..imm        continuous slices of the instruction register
//   pc_out             current PC
//   fetch_err          sticky: ack timeout or strobe issued mid-fetch
// -----------------------------------------------------------------------------
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int AW          = 16,
  parameter int IW          = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          fetch_busy,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc_out,
  output logic          fetch_err
);

  // Wide enough to hold ACK_TIMEOUT; with the timeout disabled the counter
  // simply wraps and is never compared.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  fetch_state_e  state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          pc_inc;
  logic          pc_br;
  logic [AW-1:0] pc;
  logic [CW-1:0] cnt_inc;
  logic          timeout;
  logic          seq_wr;
  logic          br_wr;

  assign seq_wr  = pc_write & ~pc_sel;
  assign br_wr   = pc_write & pc_sel;
  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (ACK_TIMEOUT != 0) && (cnt_inc == CW'(ACK_TIMEOUT));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pc_inc  = 1'b0;
    pc_br   = 1'b0;

    if (pc_rst) begin
      // Abort: any ack arriving this cycle is dropped; IR and error survive.
      state_d = FETCH_IDLE;
      req_d   = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (br_wr) begin
            pc_br = 1'b1;
          end else if (seq_wr && !ir_load) begin
            pc_inc = 1'b1;
          end
          if (ir_load) begin
            // Fetch from the PC as it is now; a sequential increment issued
            // alongside is held back until the word arrives.
            addr_d  = pc;
            req_d   = 1'b1;
            cnt_d   = '0;
            pend_d  = seq_wr;
            state_d = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (ir_load || br_wr) begin
            err_d = 1'b1;
          end
          if (imem_ack) begin
            ir_d    = imem_rdata;
            req_d   = 1'b0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            state_d = FETCH_IDLE;
            pc_inc  = pend_q | seq_wr;
          end else if (timeout) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            pend_d  = 1'b0;
            cnt_d   = '0;
            state_d = FETCH_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (seq_wr) begin
              pend_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = FETCH_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= FETCH_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  sisc_pc_reg #(
    .AW (AW)
  ) u_pc_reg (
    .clk      (clk),
    .rst_f    (rst_f),
    .pc_rst_i (pc_rst),
    .br_i     (pc_br),
    .inc_i    (pc_inc),
    .br_sel_i (br_sel),
    .imm_i    (ir_imm(ir_q[IR_W-1:0])),
    .pc_o     (pc)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign fetch_busy = (state_q == FETCH_WAIT);
  assign fetch_err  = err_q;
  assign pc_out     = pc;

  // imm and rt overlap: rt is the top nibble of the immediate.
  assign opcode = ir_field(ir_q[IR_W-1:0], OPCODE_LSB);
  assign mm     = ir_field(ir_q[IR_W-1:0], MM_LSB);
  assign rd     = ir_field(ir_q[IR_W-1:0], RD_LSB);
  assign rs     = ir_field(ir_q[IR_W-1:0], RS_LSB);
  assign rt     = ir_field(ir_q[IR_W-1:0], RT_LSB);
  assign imm    = ir_imm(ir_q[IR_W-1:0]);

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_sisc_fetch_unit
// Directed bench for the SISC fetch unit. The main instance uses the default
// ack timeout; a second instance with ACK_TIMEOUT=4 covers the timeout path.
// -----------------------------------------------------------------------------
module tb_sisc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, fetch_busy, fetch_err;
  logic [15:0] imem_addr, pc_out, imm;
  logic [3:0]  opcode, mm, rd, rs, rt;

  sisc_fetch_unit dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_busy(fetch_busy), .opcode(opcode),
    .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc_out(pc_out),
    .fetch_err(fetch_err)
  );

  // Second instance, short timeout
  logic        t_pc_write, t_ir_load, t_ack, t_zero;
  logic [31:0] t_rdata;
  logic        t_req, t_busy, t_err;
  logic [15:0] t_addr, t_pc, t_imm;
  logic [3:0]  t_opcode, t_mm, t_rd, t_rs, t_rt;

  sisc_fetch_unit #(.ACK_TIMEOUT(4)) dut4 (
    .clk(clk), .rst_f(rst_f), .pc_rst(t_zero), .pc_write(t_pc_write),
    .pc_sel(t_zero), .br_sel(t_zero), .ir_load(t_ir_load),
    .imem_req(t_req), .imem_addr(t_addr), .imem_ack(t_ack),
    .imem_rdata(t_rdata), .fetch_busy(t_busy), .opcode(t_opcode),
    .mm(t_mm), .rd(t_rd), .rs(t_rs), .rt(t_rt), .imm(t_imm), .pc_out(t_pc),
    .fetch_err(t_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the main instance: tracks architectural PC, IR,
  // outstanding fetch, deferred increment and the sticky error.
  // ---------------------------------------------------------------------------
  localparam int MODEL_TIMEOUT = 255;
  bit [15:0] m_pc, m_addr, old_pc;
  bit [31:0] m_ir;
  bit        m_busy, m_err, m_pend;
  int        m_wait;
  bit        cmp_en = 1'b0;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      m_pc = 0; m_addr = 0; m_ir = 0; m_busy = 0; m_err = 0; m_pend = 0; m_wait = 0;
    end else if (pc_rst) begin
      m_pc = 0; m_busy = 0; m_pend = 0; m_wait = 0;
    end else if (!m_busy) begin
      old_pc = m_pc;
      if (pc_write && pc_sel)
        m_pc = br_sel ? m_ir[15:0] : m_pc + m_ir[15:0];
      else if (pc_write && !ir_load)
        m_pc = m_pc + 16'd1;
      if (ir_load) begin
        m_addr = old_pc;
        m_busy = 1;
        m_wait = 0;
        m_pend = pc_write && !pc_sel;
      end
    end else begin
      if (ir_load || (pc_write && pc_sel)) m_err = 1;
      if (imem_ack) begin
        m_ir = imem_rdata;
        if (m_pend || (pc_write && !pc_sel)) m_pc = m_pc + 16'd1;
        m_busy = 0;
        m_pend = 0;
      end else begin
        m_wait++;
        if (pc_write && !pc_sel) m_pend = 1;
        if (m_wait == MODEL_TIMEOUT) begin
          m_busy = 0; m_err = 1; m_pend = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_f && cmp_en) begin
      chk("m_pc", 32'(pc_out), 32'(m_pc));
      chk("m_ir", {opcode, mm, rd, rs, imm}, m_ir);
      chk("m_rt", 32'(rt), 32'(m_ir[15:12]));
      chk("m_req", 32'(imem_req), 32'(m_busy));
      chk("m_busy", 32'(fetch_busy), 32'(m_busy));
      chk("m_err", 32'(fetch_err), 32'(m_err));
      if (m_busy) chk("m_addr", 32'(imem_addr), 32'(m_addr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // ---------------------------------------------------------------------------
  initial begin
    rst_f = 0; pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
    imem_ack = 0; imem_rdata = 0;
    t_pc_write = 0; t_ir_load = 0; t_ack = 0; t_zero = 0; t_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_pc", 32'(pc_out), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_busy", 32'(fetch_busy), 0);
    chk("rst_err", 32'(fetch_err), 0);
    rst_f = 1;
    cmp_en = 1;

    // Minimum-latency fetch with deferred increment
    ir_load = 1; pc_write = 1; pc_sel = 0; imem_rdata = 32'h8123_0000;
    @(negedge clk);
    ir_load = 0; pc_write = 0;
    chk("t1_req", 32'(imem_req), 1);
    chk("t1_addr", 32'(imem_addr), 0);
    chk("t1_pc_deferred", 32'(pc_out), 0);
    imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    chk("t1_opcode", 32'(opcode), 8);
    chk("t1_mm", 32'(mm), 1);
    chk("t1_rd", 32'(rd), 2);
    chk("t1_rs", 32'(rs), 3);
    chk("t1_pc", 32'(pc_out), 1);
    chk("t1_req_drop", 32'(imem_req), 0);

    // Ack delayed 5 cycles; increment requested during WAIT
    ir_load = 1;
    @(negedge clk);
    ir_load = 0; pc_write = 1; pc_sel = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_req_held", 32'(imem_req), 1);
      chk("t2_addr_held", 32'(imem_addr), 1);
      chk("t2_busy", 32'(fetch_busy), 1);
      chk("t2_pc_held", 32'(pc_out), 1);
      if (i == 5) begin
        imem_ack = 1; imem_rdata = 32'h4000_FFFE;
      end
      @(negedge clk);
      pc_write = 0;
    end
    imem_ack = 0;
    chk("t2_pc_on_ack", 32'(pc_out), 2);
    chk("t2_req_drop", 32'(imem_req), 0);
    chk("t2_imm", 32'(imm), 32'h0000_FFFE);

    // Step PC to 0x10, then relative branch by -2
    pc_write = 1; pc_sel = 0;
    repeat (14) @(negedge clk);
    pc_write = 0;
    chk("t3_pc_seq", 32'(pc_out), 32'h10);
    pc_write = 1; pc_sel = 1; br_sel = 0;
    @(negedge clk);
    pc_write = 0; pc_sel = 0;
    chk("t3_br_rel", 32'(pc_out), 32'h0E);

    // Absolute branch to 0x40
    ir_load = 1;
    @(negedge clk);
    ir_load = 0; imem_ack = 1; imem_rdata = 32'h5000_0040;
    @(negedge clk);
    imem_ack = 0;
    chk("t3_pc_no_inc", 32'(pc_out), 32'h0E);
    pc_write = 1; pc_sel = 1; br_sel = 1;
    @(negedge clk);
    pc_write = 0; pc_sel = 0; br_sel = 0;
    chk("t3_br_abs", 32'(pc_out), 32'h40);

    // Branch to 0xFFFF then sequential wrap to 0
    ir_load = 1;
    @(negedge clk);
    ir_load = 0; imem_ack = 1; imem_rdata = 32'h4000_FFFF;
    @(negedge clk);
    imem_ack = 0;
    pc_write = 1; pc_sel = 1; br_sel = 1;
    @(negedge clk);
    pc_sel = 0; br_sel = 0;
    chk("t4_pc_ffff", 32'(pc_out), 32'hFFFF);
    @(negedge clk);
    pc_write = 0;
    chk("t4_pc_wrap", 32'(pc_out), 0);

    // Stray ack with no request outstanding
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 0;
    chk("t5_ir_kept", 32'(imm), 32'h0000_FFFF);
    chk("t5_no_err", 32'(fetch_err), 0);

    // pc_rst during WAIT with ack in the same cycle
    pc_write = 1;
    @(negedge clk);
    pc_write = 0; ir_load = 1;
    @(negedge clk);
    ir_load = 0; pc_rst = 1; imem_ack = 1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    pc_rst = 0; imem_ack = 0;
    chk("t6_pc", 32'(pc_out), 0);
    chk("t6_busy", 32'(fetch_busy), 0);
    chk("t6_req", 32'(imem_req), 0);
    chk("t6_opcode_kept", 32'(opcode), 4);

    // ir_load during WAIT is a protocol violation
    chk("t7_err_before", 32'(fetch_err), 0);
    ir_load = 1;
    @(negedge clk);
    @(negedge clk);
    ir_load = 0;
    chk("t7_err", 32'(fetch_err), 1);
    chk("t7_req", 32'(imem_req), 1);
    chk("t7_addr", 32'(imem_addr), 0);
    imem_ack = 1; imem_rdata = 32'h1000_0005;
    @(negedge clk);
    imem_ack = 0;
    chk("t7_opcode", 32'(opcode), 1);

    // Async reset in the middle of WAIT
    ir_load = 1;
    @(negedge clk);
    ir_load = 0;
    #2 rst_f = 0;
    #1;
    chk("t8_req", 32'(imem_req), 0);
    chk("t8_busy", 32'(fetch_busy), 0);
    chk("t8_pc", 32'(pc_out), 0);
    chk("t8_opcode", 32'(opcode), 0);
    chk("t8_err", 32'(fetch_err), 0);
    @(negedge clk);
    rst_f = 1;

    // Timeout on the ACK_TIMEOUT=4 instance
    t_pc_write = 1;
    @(negedge clk);
    t_pc_write = 0; t_ir_load = 1;
    @(negedge clk);
    t_ir_load = 0; t_ack = 1; t_rdata = 32'h3000_ABCD;
    @(negedge clk);
    t_ack = 0;
    chk("to_pc_start", 32'(t_pc), 1);
    chk("to_opcode", 32'(t_opcode), 3);
    t_ir_load = 1;
    @(negedge clk);
    t_ir_load = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req_wait", 32'(t_req), 1);
      chk("to_err_wait", 32'(t_err), 0);
      @(negedge clk);
    end
    chk("to_req_drop", 32'(t_req), 0);
    chk("to_err", 32'(t_err), 1);
    chk("to_busy", 32'(t_busy), 0);
    chk("to_pc_kept", 32'(t_pc), 1);
    chk("to_imm_kept", 32'(t_imm), 32'h0000_ABCD);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
